dmem_responder: RTL and testbench

//  Memory-side responder for the CPU MEM stage: accepts one load/store request at a time over a

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_array.sv | 18 +
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, transfer sizes and data width for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_DWORD = 2'd3;
  localparam int DATA_W = 64;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 64-bit storage, synchronous per-byte writes, combinational read, never reset
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [7:0]        we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write each enabled byte lane of the addressed word
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem[addr_i];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with programmable latency
// Optional DMEM_ALIGN_CHECK_EN: misaligned doubleword accesses are suppressed and flagged on resp_err.
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int AL = AW + 3;
  dmem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic write_q, write_d, err_q, err_d;
  logic [1:0] size_q, size_d;
  logic [AL-1:0] addr_q, addr_d, acc_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, acc_wdata, arr_wdata, arr_rdata;
  logic [7:0] arr_we;
  logic idle_hs, do_access, acc_write, acc_byte, acc_err, unused_addr;
  assign unused_addr = ^req_addr[63:AL];
  assign idle_hs = state_q == IDLE && req_valid;
  assign do_access = (state_q == WAIT && cnt_q == 4'd0) || (idle_hs && LATENCY == 1);
  assign acc_write = state_q == IDLE ? req_write : write_q;
  assign acc_byte = (state_q == IDLE ? req_size : size_q) == SIZE_BYTE;
  assign acc_addr = state_q == IDLE ? req_addr[AL-1:0] : addr_q;
  assign acc_wdata = state_q == IDLE ? req_wdata : wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = !acc_byte && acc_addr[2:0] != 3'd0;
`else
  assign acc_err = 1'b0;
`endif
  assign arr_we = (reset && do_access && acc_write && !acc_err) ? (acc_byte ? 8'd1 << acc_addr[2:0] : 8'hFF) : 8'h00;
  assign arr_wdata = acc_byte ? {8{acc_wdata[7:0]}} : acc_wdata;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (acc_addr[AL-1:3]),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );
  // state, counter, latched request and response registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      write_q <= 1'b0;
      size_q <= SIZE_BYTE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      write_q <= write_d;
      size_q <= size_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  // next state: accept in IDLE, count down in WAIT, hold response in RESP until consumed
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    write_d = write_q;
    size_d = size_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        size_d = req_size;
        addr_d = req_addr[AL-1:0];
        wdata_d = req_wdata;
        cnt_d = 4'(LATENCY - 1);
        state_d = LATENCY == 1 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? RESP : WAIT;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      rdata_d = (acc_write || acc_err) ? '0 : acc_byte ? {56'b0, arr_rdata[{acc_addr[2:0], 3'b000} +: 8]} : arr_rdata;
      err_d = acc_err;
    end
  end
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (LATENCY=2, DEPTH=1024)
module tb_dmem_responder;
  import dmem_pkg::*;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, resp_valid, resp_ready = 1'b0, resp_err;
  logic [1:0] req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic [63:0] rd, held;
  logic re;
  int n_chk = 0, n_fail = 0;
  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] r, output logic e);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    chk("busy_ready", {63'b0, req_ready}, 64'd0);
    chk("lat0_valid", {63'b0, resp_valid}, 64'd0);
    tick();
    chk("lat1_valid", {63'b0, resp_valid}, 64'd0);
    tick();
    chk("lat2_valid", {63'b0, resp_valid}, 64'd1);
    r = resp_rdata;
    e = resp_err;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("hs_ready", {63'b0, req_ready}, 64'd1);
    chk("hs_valid", {63'b0, resp_valid}, 64'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_err", {63'b0, resp_err}, 64'd0);
    reset = 1'b1;
    tick();
    xfer(1'b1, SIZE_DWORD, 64'h40, 64'h0123456789ABCDEF, rd, re);
    chk("st_rdata", rd, 64'd0);
    chk("st_err", {63'b0, re}, 64'd0);
    xfer(1'b0, SIZE_DWORD, 64'h40, 64'd0, rd, re);
    chk("ld_dword", rd, 64'h0123456789ABCDEF);
    chk("ld_err", {63'b0, re}, 64'd0);
    xfer(1'b1, SIZE_BYTE, 64'h43, 64'hFFFF_FFFF_FFFF_FFAA, rd, re);
    xfer(1'b0, SIZE_DWORD, 64'h40, 64'd0, rd, re);
    chk("ld_after_sb", rd, 64'h01234567AAABCDEF);
    xfer(1'b0, SIZE_BYTE, 64'h43, 64'd0, rd, re);
    chk("lb_43", rd, 64'hAA);
    xfer(1'b0, SIZE_BYTE, 64'h41, 64'd0, rd, re);
    chk("lb_41", rd, 64'hCD);
    xfer(1'b0, SIZE_DWORD, 64'h2040, 64'd0, rd, re);
    chk("ld_alias", rd, 64'h01234567AAABCDEF);
    // backpressure: response held while a second request is ignored
    req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_DWORD; req_addr = 64'h40;
    tick();
    req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'h5A5A5A5A5A5A5A5A;
    tick();
    tick();
    chk("bp_valid0", {63'b0, resp_valid}, 64'd1);
    held = resp_rdata;
    chk("bp_rdata0", held, 64'h01234567AAABCDEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {63'b0, resp_valid}, 64'd1);
      chk("bp_rdata", resp_rdata, 64'h01234567AAABCDEF);
      chk("bp_ready", {63'b0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_hs_valid", {63'b0, resp_valid}, 64'd0);
    chk("bp_hs_ready", {63'b0, req_ready}, 64'd1);
    xfer(1'b0, SIZE_DWORD, 64'h40, 64'd0, rd, re);
    chk("bp_ignored", rd, 64'h01234567AAABCDEF);
    // reset during WAIT aborts a pending store
    xfer(1'b1, SIZE_DWORD, 64'h80, 64'hDEADBEEFCAFEF00D, rd, re);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_DWORD; req_addr = 64'h80; req_wdata = 64'h5555555555555555;
    tick();
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_ready", {63'b0, req_ready}, 64'd1);
    chk("abort_valid", {63'b0, resp_valid}, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("abort_noresp", {63'b0, resp_valid}, 64'd0);
    xfer(1'b0, SIZE_DWORD, 64'h80, 64'd0, rd, re);
    chk("abort_old", rd, 64'hDEADBEEFCAFEF00D);
    // misaligned doubleword store
    xfer(1'b1, SIZE_DWORD, 64'h44, 64'h7777777777777777, rd, re);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_st_err", {63'b0, re}, 64'd1);
    chk("mis_st_rdata", rd, 64'd0);
    xfer(1'b0, SIZE_DWORD, 64'h40, 64'd0, rd, re);
    chk("mis_unchanged", rd, 64'h01234567AAABCDEF);
    xfer(1'b0, SIZE_DWORD, 64'h44, 64'd0, rd, re);
    chk("mis_ld_err", {63'b0, re}, 64'd1);
    chk("mis_ld_rdata", rd, 64'd0);
    xfer(1'b0, SIZE_BYTE, 64'h44, 64'd0, rd, re);
    chk("mis_lb", rd, 64'h67);
    chk("mis_lb_err", {63'b0, re}, 64'd0);
`else
    chk("mis_st_err", {63'b0, re}, 64'd0);
    xfer(1'b0, SIZE_DWORD, 64'h40, 64'd0, rd, re);
    chk("mis_written", rd, 64'h7777777777777777);
    xfer(1'b0, SIZE_DWORD, 64'h44, 64'd0, rd, re);
    chk("mis_ld", rd, 64'h7777777777777777);
    chk("mis_ld_err", {63'b0, re}, 64'd0);
    xfer(1'b0, SIZE_BYTE, 64'h44, 64'd0, rd, re);
    chk("mis_lb", rd, 64'h77);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
